branch_resolve_unit: RTL and testbench

//  Parametrised EX-stage branch resolver with an internal 2-bit branch history table (BHT).

---
 rtl/branch_pkg.sv | 34 +++
 rtl/branch_resolve_unit_bht.sv | 30 +++
 rtl/branch_resolve_unit.sv | 170 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch resolve unit: op encodings, BHT counter type, FSM states.
package branch_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_op_e;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_WEAK_NT = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_FLUSH
  } brs_state_e;

  // 2-bit saturating counter step
  function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic tk);
    bht_ctr_t n;
    n = c;
    if (tk && c != 2'b11) n = c + 2'b01;
    else if (!tk && c != 2'b00) n = c - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: async read for fetch, read-modify-write update port.
module branch_bht
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= BHT_WEAK_NT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= bht_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

  // Read sees the pre-update value when lookup and update hit the same entry.
  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: compare, registered result, mispredict flush FSM, BHT and stats.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BHT_DEPTH = 64,
  parameter int              FLUSH_CYC = 2,
  parameter logic [XLEN-1:0] RESET_PC  = 'h00400004
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      br_op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm_target,
  input  logic            pred_taken,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  br_op_e          op;
  logic            is_cond, is_jal, is_jalr, op_valid;
  logic            cond_tk, taken_c;
  logic [XLEN-1:0] target_c, jalr_sum;
  logic            accept, handoff;

  logic            out_valid_q, taken_q, mp_q, cond_q;
  logic [XLEN-1:0] target_q, redirect_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]     br_cnt_q, mp_cnt_q;
  brs_state_e      state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]      fetch_ctr;
  logic            unused_bits;

  assign op       = br_op_e'(br_op);
  assign is_jal   = (op == BR_JAL);
  assign is_jalr  = (op == BR_JALR);
  assign is_cond  = (op == BR_BEQ) || (op == BR_BNE) || (op == BR_BLT) ||
                    (op == BR_BGE) || (op == BR_BLTU) || (op == BR_BGEU);
  assign op_valid = is_cond | is_jal | is_jalr;

  always_comb begin
    cond_tk = 1'b0;
    case (op)
      BR_BEQ:  cond_tk = (rs1 == rs2);
      BR_BNE:  cond_tk = (rs1 != rs2);
      BR_BLT:  cond_tk = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  cond_tk = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: cond_tk = (rs1 <  rs2);
      BR_BGEU: cond_tk = (rs1 >= rs2);
      default: cond_tk = 1'b0;
    endcase
  end

  assign jalr_sum = rs1 + imm_target;
  assign taken_c  = cond_tk | is_jal | is_jalr;

  always_comb begin
    target_c = pc + XLEN'(4);
    if (is_jalr)              target_c = {jalr_sum[XLEN-1:1], 1'b0};
    else if (is_jal | cond_tk) target_c = imm_target;
  end

  assign in_ready = (state_q != S_FLUSH) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  // Result register; none-ops pass through without touching it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      mp_q        <= 1'b0;
      cond_q      <= 1'b0;
      idx_q       <= '0;
    end else if (accept && op_valid) begin
      out_valid_q <= 1'b1;
      taken_q     <= taken_c;
      target_q    <= target_c;
      mp_q        <= taken_c ^ pred_taken;
      cond_q      <= is_cond;
      idx_q       <= pc[IDX_W+1:2];
    end else if (handoff) begin
      out_valid_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_FLUSH: begin
        if (fcnt_q == '0) state_d = S_IDLE;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: begin
        if (handoff && mp_q) begin
          state_d = S_FLUSH;
          fcnt_d  = CNT_W'(FLUSH_CYC - 1);
        end else if ((accept && op_valid) || (out_valid_q && !out_ready)) begin
          state_d = S_RESOLVE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fcnt_q     <= '0;
      redirect_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (handoff && mp_q && state_q != S_FLUSH) redirect_q <= target_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (handoff) begin
      if (cond_q && br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (mp_q   && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  branch_bht #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (fetch_pc[IDX_W+1:2]),
    .rd_ctr_o   (fetch_ctr),
    .wr_en_i    (handoff && cond_q),
    .wr_idx_i   (idx_q),
    .wr_taken_i (taken_q)
  );

  assign unused_bits = ^{pc[XLEN-1:IDX_W+2], pc[1:0], fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign mispredict  = out_valid_q && mp_q;
  assign flush       = (state_q == S_FLUSH);
  assign redirect_pc = redirect_q;
  assign fetch_pred  = fetch_ctr[1];
  assign br_count    = br_cnt_q;
  assign mp_count    = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized checks of branch_resolve_unit against a transaction-level model.
module tb_branch_resolve_unit;

  localparam int          FLUSH_CYC = 2;
  localparam logic [31:0] RESET_PC  = 32'h00400004;

  logic        clk = 0, reset = 1, in_valid = 0, pred_taken = 0, out_ready = 1;
  logic [3:0]  br_op = 0;
  logic [31:0] pc = 0, rs1 = 0, rs2 = 0, imm_target = 0, fetch_pc = 0;
  logic        in_ready, out_valid, taken, mispredict, flush, fetch_pred;
  logic [31:0] target, redirect_pc, br_count, mp_count;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .FLUSH_CYC(FLUSH_CYC), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .br_op(br_op),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm_target(imm_target), .pred_taken(pred_taken),
    .out_ready(out_ready), .out_valid(out_valid), .taken(taken), .target(target),
    .mispredict(mispredict), .flush(flush), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .fetch_pred(fetch_pred), .br_count(br_count), .mp_count(mp_count));

  always #5 clk = ~clk;

  int passed = 0, failed = 0, total = 0;

  // model state
  int          m_bht [64];
  int          m_br, m_mp;
  bit          p_v, p_cond, p_mp, p_tk;
  int          p_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  // Resolution rules expressed arithmetically
  function automatic void ref_resolve(input int op, input logic [31:0] a_pc, a1, a2, aimm,
                                      output bit ok, output bit cond, output bit tk,
                                      output logic [31:0] tg);
    longint u1, u2, s1, s2;
    u1 = longint'({32'b0, a1});  u2 = longint'({32'b0, a2});
    s1 = longint'(int'(a1));     s2 = longint'(int'(a2));
    ok = (op >= 1 && op <= 8);
    cond = (op >= 1 && op <= 6);
    case (op)
      1: tk = (u1 == u2);
      2: tk = (u1 != u2);
      3: tk = (s1 < s2);
      4: tk = (s1 >= s2);
      5: tk = (u1 < u2);
      6: tk = (u1 >= u2);
      7, 8: tk = 1;
      default: tk = 0;
    endcase
    if (op == 8)      tg = 32'((u1 + longint'({32'b0, aimm})) / 2 * 2);
    else if (tk)      tg = aimm;
    else              tg = 32'((u2 - u2 + longint'({32'b0, a_pc}) + 4) % 64'h1_0000_0000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_br = 0; m_mp = 0; p_v = 0;
  endtask

  task automatic model_handoff();
    if (p_v) begin
      if (p_cond) begin
        m_br++;
        if (p_tk) m_bht[p_idx] = (m_bht[p_idx] == 3) ? 3 : m_bht[p_idx] + 1;
        else      m_bht[p_idx] = (m_bht[p_idx] == 0) ? 0 : m_bht[p_idx] - 1;
      end
      if (p_mp) m_mp++;
      p_v = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0; out_ready = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  // Issue one op; returns at the negedge where its result is visible (unless it flushed).
  task automatic run_op(input int op, input logic [31:0] a_pc, a1, a2, aimm,
                        input bit apred, input int stall);
    bit ok, cond, tk;
    logic [31:0] tg;
    int idx;
    ref_resolve(op, a_pc, a1, a2, aimm, ok, cond, tk, tg);
    idx = idx_of(a_pc);
    @(negedge clk);
    in_valid = 1; br_op = 4'(op); pc = a_pc; rs1 = a1; rs2 = a2; imm_target = aimm;
    pred_taken = apred; out_ready = 1; fetch_pc = a_pc;
    #1 chk("in_ready_accept", in_ready, 1);
    model_handoff();
    @(negedge clk);
    in_valid = 0;
    chk("fetch_pred_preupd", fetch_pred, m_bht[idx] / 2);
    chk("br_count", br_count, m_br);
    chk("mp_count", mp_count, m_mp);
    if (!ok) begin
      chk("noneop_out_valid", out_valid, 0);
      return;
    end
    chk("out_valid", out_valid, 1);
    chk("taken", taken, tk);
    chk("target", target, tg);
    chk("mispredict", mispredict, tk ^ apred);
    p_v = 1; p_cond = cond; p_tk = tk; p_mp = tk ^ apred; p_idx = idx;
    for (int j = 0; j < stall; j++) begin
      out_ready = 0;
      #1 chk("held_in_ready", in_ready, 0);
      @(negedge clk);
      chk("held_out_valid", out_valid, 1);
      chk("held_target", target, tg);
      chk("held_br_count", br_count, m_br);
      chk("held_fetch_pred", fetch_pred, m_bht[idx] / 2);
    end
    out_ready = 1;
    if (p_mp) begin
      model_handoff();
      for (int j = 0; j < FLUSH_CYC; j++) begin
        @(negedge clk);
        chk("flush_on", flush, 1);
        chk("flush_in_ready", in_ready, 0);
        chk("redirect_pc", redirect_pc, tg);
      end
      @(negedge clk);
      chk("flush_off", flush, 0);
      chk("post_flush_in_ready", in_ready, 1);
      chk("mp_count_flush", mp_count, m_mp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    model_handoff();
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_br_count", br_count, m_br);
    chk("drain_mp_count", mp_count, m_mp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_target", target, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, RESET_PC);
    chk("rst_br_count", br_count, 0);
    chk("rst_mp_count", mp_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fetch_pred", fetch_pred, 0);

    // signed vs unsigned compare
    run_op(3, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h240, 1, 0);
    chk("blt_taken", taken, 1);
    run_op(5, 32'h300, 32'hFFFFFFFF, 32'd1, 32'h340, 0, 0);
    chk("bltu_taken", taken, 0);
    drain();

    // BHT training at 0x100 from reset; first BEQ mispredicts and redirects to 0x140
    do_reset();
    run_op(1, 32'h100, 32'd5, 32'd5, 32'h140, 0, 0);
    chk("beq_redirect", redirect_pc, 32'h140);
    fetch_pc = 32'h100;
    #1 chk("bht_after_first", fetch_pred, 1);
    for (int k = 0; k < 3; k++) run_op(1, 32'h100, 32'd5, 32'd5, 32'h140, 1, 0);
    drain();
    chk("bht_saturated", fetch_pred, 1);
    run_op(1, 32'h100, 32'd1, 32'd2, 32'h140, 1, 0);
    run_op(1, 32'h100, 32'd1, 32'd2, 32'h140, 1, 0);
    drain();
    fetch_pc = 32'h100;
    #1 chk("bht_after_dec2", fetch_pred, m_bht[idx_of(32'h100)] / 2);

    // JALR alignment and pc+4 wrap
    run_op(8, 32'h500, 32'h1003, 32'h0, 32'h10, 1, 0);
    chk("jalr_target", target, 32'h1012);
    run_op(2, 32'hFFFFFFFC, 32'd7, 32'd7, 32'h80, 0, 0);
    chk("bne_wrap_target", target, 32'h0);

    // backpressure
    run_op(4, 32'h600, 32'd3, 32'd3, 32'h700, 1, 3);
    drain();

    // reset in second flush cycle after BHT[0x100] has moved above weak-not-taken
    @(negedge clk);
    in_valid = 1; br_op = 4'd1; pc = 32'h100; rs1 = 1; rs2 = 1; imm_target = 32'h180;
    pred_taken = 0; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("mf_flush1", flush, 1);
    @(negedge clk);
    chk("mf_flush2", flush, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    fetch_pc = 32'h100;
    #1;
    chk("mf_flush_cleared", flush, 0);
    chk("mf_redirect", redirect_pc, RESET_PC);
    chk("mf_out_valid", out_valid, 0);
    chk("mf_br_count", br_count, 0);
    chk("mf_mp_count", mp_count, 0);
    chk("mf_bht_reset", fetch_pred, 0);
    chk("mf_in_ready", in_ready, 1);

    // reset with a held result: no BHT update for it
    @(negedge clk);
    in_valid = 1; br_op = 4'd1; pc = 32'h100; rs1 = 2; rs2 = 2; imm_target = 32'h180;
    pred_taken = 1;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; out_ready = 1;
    model_reset();
    @(negedge clk);
    chk("hr_out_valid", out_valid, 0);
    chk("hr_br_count", br_count, 0);
    run_op(1, 32'h100, 32'd9, 32'd9, 32'h180, 1, 0);
    drain();
    fetch_pc = 32'h100;
    #1 chk("hr_weak_nt_step", fetch_pred, 1);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int op, st;
      logic [31:0] a_pc, a1, a2, aimm;
      op   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
      a_pc = {22'($urandom_range(0, 3) == 0 ? 22'h3FFFFF : 22'h0), 8'($urandom), 2'b00};
      a1   = $urandom;
      case ($urandom_range(0, 3))
        0: a2 = a1;
        1: a2 = ~a1;
        default: a2 = $urandom;
      endcase
      aimm = $urandom;
      st   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_op(op, a_pc, a1, a2, aimm, 1'($urandom_range(0, 1)), st);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
